// File: rtl/dma_pkg.sv
// Shared definitions for the DMA word-copy engine: register map, CTRL bit
// positions, bus access-size encodings and the copy FSM states.
package dma_pkg;

  localparam logic [3:0] OFF_SRC  = 4'h0;
  localparam logic [3:0] OFF_DST  = 4'h4;
  localparam logic [3:0] OFF_LEN  = 4'h8;
  localparam logic [3:0] OFF_CTRL = 4'hC;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 0;
  localparam int unsigned CTRL_DONE  = 1;
  localparam int unsigned CTRL_IE    = 2;
  localparam int unsigned CTRL_ABORT = 3;

  localparam logic [1:0] SEL_BYTE = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_bus_master.sv
// Single-transaction bus initiator: launches a read or write on a request
// pulse and holds address/data/strobe until the responder acks.
module dma_bus_master
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_rd,
  input  logic        req_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  output logic [1:0]  m_sel_o,
  output logic        m_rd_o,
  output logic        m_we_o,
  input  logic [31:0] m_data_i,
  input  logic        m_ack_i
);

  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [1:0]  sel_q;
  logic        rd_q, rd_d, we_q, we_d;

  // A new request may be loaded on the ack edge, giving back-to-back RD/WR.
  always_comb begin
    done  = (rd_q | we_q) & m_ack_i;
    rdata = m_data_i;
    if (req_rd || req_we) begin
      rd_d   = req_rd;
      we_d   = req_we;
      addr_d = addr;
      data_d = wdata;
    end else if (done) begin
      rd_d   = 1'b0;
      we_d   = 1'b0;
      addr_d = 32'h0;
      data_d = 32'h0;
    end else begin
      rd_d   = rd_q;
      we_d   = we_q;
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= 32'h0;
      data_q <= 32'h0;
      sel_q  <= 2'b00;
    end else begin
      rd_q   <= rd_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sel_q  <= SEL_WORD;
    end
  end

  assign m_addr_o = addr_q;
  assign m_data_o = data_q;
  assign m_sel_o  = sel_q;
  assign m_rd_o   = rd_q;
  assign m_we_o   = we_q;

endmodule

// File: rtl/dma_engine.sv
// Register-programmed word-copy engine: responder register file plus the
// RD/WR copy FSM driving a dma_bus_master initiator.
module dma_engine
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic [1:0]  sel_i,
  input  logic        rd_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  input  logic [31:0] m_data_i,
  output logic [1:0]  m_sel_o,
  output logic        m_rd_o,
  output logic        m_we_o,
  input  logic        m_ack_i,
  output logic        interrupt
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ie_q, ie_d, done_q, done_d, abort_q, abort_d, irq_q, irq_d;
  logic             ack_q, ack_d, wr_pend_q, wr_pend_d;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [31:0]      wr_data_q, wr_data_d, rdata_q, rdata_d, ctrl_rd_s;
  logic             busy_s, acc_s, ctrl_wr_s, req_rd_s, req_we_s, bm_done_s;
  logic [31:0]      bm_addr_s, bm_wdata_s, bm_rdata_s;
  logic             unused_s;

  assign busy_s   = (state_q != ST_IDLE);
  assign unused_s = ^{addr_i[31:4], addr_i[1:0]};

  // Responder: ack and read data one cycle after a fresh request; writes are
  // captured here and committed on the following edge.
  always_comb begin
    acc_s     = (rd_i | we_i) & ~ack_q;
    ack_d     = acc_s;
    wr_pend_d = acc_s & we_i & (sel_i == SEL_WORD);
    wr_idx_d  = addr_i[3:2];
    wr_data_d = data_i;
    ctrl_rd_s = 32'h0;
    ctrl_rd_s[CTRL_BUSY] = busy_s;
    ctrl_rd_s[CTRL_DONE] = done_q;
    ctrl_rd_s[CTRL_IE]   = ie_q;
    if (acc_s && rd_i && (sel_i == SEL_WORD)) begin
      case ({addr_i[3:2], 2'b00})
        OFF_SRC:  rdata_d = src_q;
        OFF_DST:  rdata_d = dst_q;
        OFF_LEN:  rdata_d = {{(32-LEN_W){1'b0}}, len_q};
        OFF_CTRL: rdata_d = ctrl_rd_s;
        default:  rdata_d = 32'h0;
      endcase
    end else begin
      rdata_d = 32'h0;
    end
  end

  // Register commits and copy FSM; SRC/DST/LEN double as the working registers.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    len_d      = len_q;
    ie_d       = ie_q;
    done_d     = done_q;
    req_rd_s   = 1'b0;
    req_we_s   = 1'b0;
    bm_addr_s  = 32'h0;
    bm_wdata_s = 32'h0;
    ctrl_wr_s  = wr_pend_q && ({wr_idx_q, 2'b00} == OFF_CTRL);

    if (wr_pend_q && !busy_s) begin
      case ({wr_idx_q, 2'b00})
        OFF_SRC: src_d = {wr_data_q[31:2], 2'b00};
        OFF_DST: dst_d = {wr_data_q[31:2], 2'b00};
        OFF_LEN: len_d = wr_data_q[LEN_W-1:0];
        default: len_d = len_q;
      endcase
    end else begin
      len_d = len_q;
    end

    if (ctrl_wr_s) begin
      ie_d   = wr_data_q[CTRL_IE];
      done_d = done_q & ~wr_data_q[CTRL_DONE];
    end else begin
      ie_d   = ie_q;
      done_d = done_q;
    end

    if (state_q == ST_RD || state_q == ST_WR) begin
      abort_d = abort_q | (ctrl_wr_s & wr_data_q[CTRL_ABORT]);
    end else begin
      abort_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr_s && wr_data_q[CTRL_START]) begin
          if (len_q != LEN_ZERO) begin
            state_d   = ST_RD;
            req_rd_s  = 1'b1;
            bm_addr_s = src_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (bm_done_s) begin
          state_d    = ST_WR;
          req_we_s   = 1'b1;
          bm_addr_s  = dst_q;
          bm_wdata_s = bm_rdata_s;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        if (bm_done_s) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          len_d = len_q - LEN_ONE;
          if (len_q == LEN_ONE || abort_q) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RD;
            req_rd_s  = 1'b1;
            bm_addr_s = src_q + 32'd4;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = done_d & ie_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      src_q     <= 32'h0;
      dst_q     <= 32'h0;
      len_q     <= LEN_ZERO;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 2'b00;
      wr_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  dma_bus_master u_bm (
    .clk      (clk),
    .rstn     (rstn),
    .req_rd   (req_rd_s),
    .req_we   (req_we_s),
    .addr     (bm_addr_s),
    .wdata    (bm_wdata_s),
    .done     (bm_done_s),
    .rdata    (bm_rdata_s),
    .m_addr_o (m_addr_o),
    .m_data_o (m_data_o),
    .m_sel_o  (m_sel_o),
    .m_rd_o   (m_rd_o),
    .m_we_o   (m_we_o),
    .m_data_i (m_data_i),
    .m_ack_i  (m_ack_i)
  );

  assign ack_o     = ack_q;
  assign data_o    = rdata_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_dma_engine.sv
// Self-checking bench for dma_engine: register vector table, memory model
// with configurable wait states and a scoreboard of expected bus transactions.
module tb_dma_engine;

  logic        clk, rstn;
  logic [31:0] addr_i, data_i, data_o, m_addr_o, m_data_o, m_data_i;
  logic [1:0]  sel_i, m_sel_o;
  logic        rd_i, we_i, ack_o, m_rd_o, m_we_o, m_ack_i, interrupt;

  dma_engine #(.LEN_W(16)) dut (
    .clk(clk), .rstn(rstn), .addr_i(addr_i), .data_i(data_i), .data_o(data_o),
    .sel_i(sel_i), .rd_i(rd_i), .we_i(we_i), .ack_o(ack_o),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_data_i(m_data_i), .m_sel_o(m_sel_o),
    .m_rd_o(m_rd_o), .m_we_o(m_we_o), .m_ack_i(m_ack_i), .interrupt(interrupt)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct { logic we; logic [3:0] addr; logic [1:0] sel; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  txn_t        exp_q[$];
  int          rd_cyc[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0, errors = 0;
  int          cyc = 0, wait_n = 0, rd_seen = 0, we_seen = 0;
  logic        seen;
  logic [31:0] rec_addr, rec_data;
  logic        rec_rd, rec_we;
  int          wcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: first sight, wait_n wait cycles, then a one-cycle ack.
  initial begin
    m_ack_i = 1'b0; m_data_i = 32'h0; seen = 1'b0; wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        m_ack_i = 1'b0; m_data_i = 32'h0; seen = 1'b0;
      end else begin
        if (m_ack_i) begin m_ack_i = 1'b0; seen = 1'b0; m_data_i = 32'hBADBAD00; end
        if (m_rd_o || m_we_o) begin
          if (!seen) begin
            seen = 1'b1; wcnt = 0;
            rec_addr = m_addr_o; rec_data = m_data_o; rec_rd = m_rd_o; rec_we = m_we_o;
            chk("m_sel_word", {30'h0, m_sel_o}, 32'h2);
            if (m_rd_o) begin rd_seen++; rd_cyc.push_back(cyc); end
            else we_seen++;
          end else begin
            chk("hold_addr", m_addr_o, rec_addr);
            chk("hold_data", m_data_o, rec_data);
            chk("hold_strobe", {30'h0, m_rd_o, m_we_o}, {30'h0, rec_rd, rec_we});
            if (wcnt == wait_n) begin
              m_ack_i = 1'b1;
              if (m_rd_o) m_data_i = mem.exists(m_addr_o) ? mem[m_addr_o] : 32'h0;
              else mem[m_addr_o] = m_data_o;
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected actual=addr %h we %b required=no transaction", m_addr_o, m_we_o);
              end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("sb_kind", {31'h0, m_we_o}, {31'h0, e.we});
                chk("sb_addr", m_addr_o, e.addr);
                if (m_we_o) chk("sb_wdata", m_data_o, e.data);
              end
            end else begin
              wcnt++;
            end
          end
        end
      end
    end
  end

  task automatic bus_acc(input logic we, input logic [3:0] a, input logic [1:0] sel,
                         input logic [31:0] wd, output logic [31:0] rd, output logic ackd);
    @(negedge clk);
    addr_i = {28'h0, a}; data_i = wd; sel_i = sel; we_i = we; rd_i = ~we;
    @(negedge clk);
    ackd = ack_o; rd = data_o;
    we_i = 1'b0; rd_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r; logic k;
    bus_acc(1'b1, a, 2'b10, d, r, k);
    chk("wr_ack", {31'h0, k}, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r; logic k;
    bus_acc(1'b0, a, 2'b10, 32'h0, r, k);
    chk("rd_ack", {31'h0, k}, 32'h1);
    chk(name, r, exp);
  endtask

  task automatic wait_irq(input string name, input int maxc);
    int k = 0;
    while (!interrupt && k < maxc) begin @(negedge clk); k++; end
    chk(name, {31'h0, interrupt}, 32'h1);
  endtask

  // Seed n source words, expect n_exp RD/WR pairs, program SRC/DST/LEN and clear DONE.
  task automatic setup(input logic [31:0] src, input logic [31:0] dst, input int n,
                       input int n_exp, input logic [31:0] seed);
    txn_t t;
    for (int i = 0; i < n; i++) mem[src + 32'(4*i)] = seed + 32'(i);
    for (int i = 0; i < n_exp; i++) begin
      t.we = 1'b0; t.addr = src + 32'(4*i); t.data = 32'h0; exp_q.push_back(t);
      t.we = 1'b1; t.addr = dst + 32'(4*i); t.data = seed + 32'(i); exp_q.push_back(t);
    end
    wr(4'h0, src); wr(4'h4, dst); wr(4'h8, 32'(n)); wr(4'hC, 32'h6);
  endtask

  vec_t vecs[10];

  initial begin
    int b, rb, wb;
    vecs[0] = '{1'b1, 4'h0, 2'b10, 32'h0000_1237, 32'h0};
    vecs[1] = '{1'b0, 4'h0, 2'b10, 32'h0,         32'h0000_1234};
    vecs[2] = '{1'b1, 4'h4, 2'b10, 32'hFFFF_FFFF, 32'h0};
    vecs[3] = '{1'b0, 4'h4, 2'b10, 32'h0,         32'hFFFF_FFFC};
    vecs[4] = '{1'b1, 4'h8, 2'b10, 32'h0001_2345, 32'h0};
    vecs[5] = '{1'b1, 4'h0, 2'b00, 32'hAAAA_AAAA, 32'h0};
    vecs[6] = '{1'b0, 4'h0, 2'b10, 32'h0,         32'h0000_1234};
    vecs[7] = '{1'b0, 4'h0, 2'b01, 32'h0,         32'h0};
    vecs[8] = '{1'b1, 4'hC, 2'b10, 32'h0000_0004, 32'h0};
    vecs[9] = '{1'b0, 4'hC, 2'b10, 32'h0,         32'h0000_0004};

    rstn = 1'b0; addr_i = 32'h0; data_i = 32'h0; sel_i = 2'b00; rd_i = 1'b0; we_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {m_addr_o | m_data_o | data_o}, 32'h0);
    chk("rst_strobes", {27'h0, ack_o, m_rd_o, m_we_o, interrupt, |m_sel_o}, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      logic [31:0] r; logic k;
      bus_acc(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, r, k);
      chk($sformatf("vec%0d_ack", i), {31'h0, k}, 32'h1);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
    end
    rd_chk("len_trunc", 4'h8, 32'h0000_2345);

    // 4-word zero-wait copy with start latency check
    wait_n = 0;
    setup(32'h100, 32'h200, 4, 4, 32'hA0);
    wr(4'hC, 32'h5);
    chk("start_lat0", {31'h0, m_rd_o}, 32'h0);
    @(negedge clk);
    chk("start_lat1", {31'h0, m_rd_o}, 32'h1);
    chk("start_addr", m_addr_o, 32'h100);
    wait_irq("copy4_irq", 200);
    rd_chk("copy4_ctrl", 4'hC, 32'h6);
    chk("copy4_drained", 32'(exp_q.size()), 32'h0);
    chk("copy4_mem3", mem[32'h20C], 32'hA3);

    // LEN=0: no traffic, DONE two cycles after the CTRL ack
    rb = rd_seen; wb = we_seen;
    wr(4'h8, 32'h0); wr(4'hC, 32'h6);
    wr(4'hC, 32'h5);
    chk("len0_irq_c1", {31'h0, interrupt}, 32'h0);
    @(negedge clk);
    chk("len0_irq_c2", {31'h0, interrupt}, 32'h0);
    @(negedge clk);
    chk("len0_irq_c3", {31'h0, interrupt}, 32'h1);
    repeat (5) @(negedge clk);
    chk("len0_no_traffic", 32'((rd_seen - rb) + (we_seen - wb)), 32'h0);

    // 3 words, 5 wait states: 14 cycles per word
    wait_n = 5; b = rd_cyc.size();
    setup(32'h300, 32'h400, 3, 3, 32'hC0);
    wr(4'hC, 32'h5);
    wait_irq("wait5_irq", 300);
    chk("wait5_drained", 32'(exp_q.size()), 32'h0);
    chk("wait5_cost1", 32'(rd_cyc[b+1] - rd_cyc[b]), 32'd14);
    chk("wait5_cost2", 32'(rd_cyc[b+2] - rd_cyc[b+1]), 32'd14);

    // ABORT during RD of word 2 of 8
    wait_n = 8; rb = rd_seen;
    setup(32'h800, 32'h900, 8, 2, 32'hE0);
    wr(4'hC, 32'h5);
    b = 0;
    while (rd_seen < rb + 2 && b < 200) begin @(negedge clk); b++; end
    chk("abort_reach_rd2", 32'(rd_seen - rb), 32'd2);
    wr(4'hC, 32'hC);
    wait_irq("abort_irq", 300);
    repeat (10) @(negedge clk);
    chk("abort_rd_count", 32'(rd_seen - rb), 32'd2);
    chk("abort_drained", 32'(exp_q.size()), 32'h0);
    rd_chk("abort_len", 4'h8, 32'd6);
    rd_chk("abort_src", 4'h0, 32'h808);
    rd_chk("abort_ctrl", 4'hC, 32'h6);

    // address wrap
    wait_n = 0;
    setup(32'hFFFF_FFFC, 32'h600, 2, 2, 32'h55);
    wr(4'hC, 32'h5);
    wait_irq("wrap_irq", 200);
    chk("wrap_drained", 32'(exp_q.size()), 32'h0);
    chk("wrap_mem", mem[32'h604], 32'h56);

    // reset mid-write
    wait_n = 5;
    setup(32'hA00, 32'hB00, 3, 3, 32'h10);
    wr(4'hC, 32'h5);
    b = 0;
    while (!m_we_o && b < 100) begin @(negedge clk); b++; end
    chk("rst_reach_wr", {31'h0, m_we_o}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("arst_outs", {m_addr_o | m_data_o | data_o}, 32'h0);
    chk("arst_strobes", {27'h0, ack_o, m_rd_o, m_we_o, interrupt, |m_sel_o}, 32'h0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    rstn = 1'b1;
    rb = rd_seen; wb = we_seen;
    rd_chk("arst_ctrl", 4'hC, 32'h0);
    rd_chk("arst_src", 4'h0, 32'h0);
    repeat (20) @(negedge clk);
    chk("arst_no_traffic", 32'((rd_seen - rb) + (we_seen - wb)), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
